// File: rtl/bitonic_32_feeder_if.sv
// Stream, sorter and tag signals of bitonic_32_feeder bundled as one port.
// slave = the feeder itself; master = the upstream producer / downstream consumer side.
interface bitonic_32_feeder_if #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int IN_LANES   = 4
);
  localparam int CNTW = $clog2(DATALENGTH + 1);

  logic                                 sign_ctrl_i;
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic [IN_LANES-1:0][DATAWIDTH-1:0]   in_data_i;
  logic                                 in_last_i;
  logic [IN_LANES-1:0]                  in_keep_i;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_o;
  logic                                 sign_ctrl_o;
  logic                                 launch_o;
  logic                                 sorted_valid_o;
  logic                                 sorted_last_o;
  logic [CNTW-1:0]                      sorted_count_o;
  logic                                 credit_i;
  logic [31:0]                          stat_vec_cnt_o;
  logic [31:0]                          stat_stall_cnt_o;

  modport slave (
    input  sign_ctrl_i, in_valid_i, in_data_i, in_last_i, in_keep_i, credit_i,
    output in_ready_o, x_o, sign_ctrl_o, launch_o,
    output sorted_valid_o, sorted_last_o, sorted_count_o,
    output stat_vec_cnt_o, stat_stall_cnt_o
  );

  modport master (
    output sign_ctrl_i, in_valid_i, in_data_i, in_last_i, in_keep_i, credit_i,
    input  in_ready_o, x_o, sign_ctrl_o, launch_o,
    input  sorted_valid_o, sorted_last_o, sorted_count_o,
    input  stat_vec_cnt_o, stat_stall_cnt_o
  );
endinterface

// File: rtl/bitonic_32_feeder.sv
// Packs IN_LANES-wide beats into padded DATALENGTH vectors for the bitonic sorter, with credit flow
// control and a SORT_LATENCY tag pipe. Optional counters: define TOPK_FEED_STATS_EN.
module bitonic_32_feeder #(
  parameter int DATAWIDTH    = 8,
  parameter int DATALENGTH   = 32,
  parameter int IN_LANES     = 4,
  parameter int SORT_LATENCY = 8,
  parameter int CREDITS      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bitonic_32_feeder_if.slave  bus
);
  localparam int BEATS = DATALENGTH / IN_LANES;
  localparam int PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(CREDITS + 1);
  localparam int CNTW  = $clog2(DATALENGTH + 1);
  localparam int KW    = $clog2(IN_LANES + 1);

  typedef struct packed {
    logic            valid;
    logic            last;
    logic [CNTW-1:0] count;
  } tag_t;

  logic                                 run_q;
  logic [CW-1:0]                        credit_q;
  logic [CW-1:0]                        credit_d;
  logic [PW-1:0]                        ptr_q;
  logic                                 sign_q;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] buf_q;
  logic                                 last_q;
  logic [CNTW-1:0]                      count_q;
  tag_t                                 pipe_q [SORT_LATENCY];

  logic                                 accept;
  logic                                 first_beat;
  logic                                 full_beat;
  logic                                 empty_end;
  logic                                 commit;
  logic                                 credit_ok;
  logic                                 vec_sign;
  logic [DATAWIDTH-1:0]                 pad;
  logic [KW-1:0]                        keep_pop;
  logic [CNTW-1:0]                      vec_count;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] vec_next;

  assign bus.in_ready_o = run_q && (credit_q != '0);
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign first_beat     = (ptr_q == '0);
  assign full_beat      = (ptr_q == PW'(BEATS - 1));
  assign empty_end      = bus.in_last_i && (bus.in_keep_i == '0) && first_beat;
  assign commit         = accept && (full_beat || bus.in_last_i) && !empty_end;
  assign credit_ok      = bus.credit_i && (credit_q != CW'(CREDITS));
  // Direction is frozen by the first beat; pads must sort to the tail in that direction.
  assign vec_sign       = first_beat ? bus.sign_ctrl_i : sign_q;
  assign pad            = vec_sign ? '0 : '1;

  always_comb begin
    keep_pop = '0;
    for (int j = 0; j < IN_LANES; j++) begin
      keep_pop = keep_pop + KW'(bus.in_keep_i[j]);
    end
    vec_next = buf_q;
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < IN_LANES; j++) begin
        if (b == int'(ptr_q)) begin
          vec_next[b*IN_LANES + j] = (!bus.in_last_i || bus.in_keep_i[j]) ? bus.in_data_i[j] : pad;
        end else if (b > int'(ptr_q)) begin
          vec_next[b*IN_LANES + j] = pad;
        end
      end
    end
    vec_count = bus.in_last_i ? (CNTW'(ptr_q) * CNTW'(IN_LANES) + CNTW'(keep_pop))
                              : CNTW'(DATALENGTH);
  end

  always_comb begin
    credit_d = credit_q;
    if (commit && !credit_ok) begin
      credit_d = credit_q - CW'(1);
    end else if (!commit && credit_ok) begin
      credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q           <= 1'b0;
      credit_q        <= CW'(CREDITS);
      ptr_q           <= '0;
      sign_q          <= 1'b0;
      buf_q           <= '0;
      bus.x_o         <= '0;
      bus.sign_ctrl_o <= 1'b0;
      bus.launch_o    <= 1'b0;
      last_q          <= 1'b0;
      count_q         <= '0;
    end else begin
      run_q        <= 1'b1;
      credit_q     <= credit_d;
      bus.launch_o <= commit;
      last_q       <= commit && bus.in_last_i;
      count_q      <= commit ? vec_count : '0;
      if (accept) begin
        buf_q <= vec_next;
        if (first_beat) begin
          sign_q <= bus.sign_ctrl_i;
        end
        ptr_q <= (commit || empty_end) ? '0 : ptr_q + PW'(1);
      end
      if (commit) begin
        bus.x_o         <= vec_next;
        bus.sign_ctrl_o <= vec_sign;
      end
    end
  end

  // Tags travel alongside the sorter pipeline so valid lines up with its y_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SORT_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: bus.launch_o, last: last_q, count: count_q};
      for (int k = 1; k < SORT_LATENCY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign bus.sorted_valid_o = pipe_q[SORT_LATENCY-1].valid;
  assign bus.sorted_last_o  = pipe_q[SORT_LATENCY-1].last;
  assign bus.sorted_count_o = pipe_q[SORT_LATENCY-1].count;

`ifdef TOPK_FEED_STATS_EN
  logic [31:0] vec_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.launch_o) begin
        vec_cnt_q <= vec_cnt_q + 32'd1;
      end
      if (bus.in_valid_i && !bus.in_ready_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stat_vec_cnt_o   = vec_cnt_q;
  assign bus.stat_stall_cnt_o = stall_cnt_q;
`else
  assign bus.stat_vec_cnt_o   = '0;
  assign bus.stat_stall_cnt_o = '0;
`endif

  // A credit beyond CREDITS means the consumer lost track; keep must be a lane-0 prefix.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.credit_i && (credit_q == CW'(CREDITS))));
      assert (!(accept && bus.in_last_i) ||
              ((bus.in_keep_i & (bus.in_keep_i + IN_LANES'(1))) == '0));
    end
  end
endmodule
